// File: rtl/lz4_job_scheduler.sv
// LZ4 job scheduler: feeds one compression job at a time into the LZ4 core.
// Takes a byte-length descriptor, pulses start and length strobes, streams the
// source dwords under input-FIFO back-pressure and marks the last one with
// data_terminal, then waits for compress_done and reports length and status.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// IDLE      | job_ready=1, waiting for a descriptor
// START     | one-cycle lz_start_compress pulse
// LEN       | one-cycle lz_file_length_valid strobe, watchdog armed
// FEED      | streaming source dwords, one per cycle when unblocked
// WAIT_DONE | all dwords sent, waiting for lz_compress_done
// REPORT    | one-cycle job_done with job_status / job_clen
module lz4_job_scheduler #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'hFFFFF,
    parameter logic [31:0] MAX_LEN        = 32'h00400000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [31:0] job_len,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] src_data,
    input  logic        src_valid,
    output logic        src_rd,
    output logic        lz_start_compress,
    output logic [31:0] lz_file_length,
    output logic        lz_file_length_valid,
    output logic [31:0] lz_idata,
    output logic        lz_idata_req,
    output logic        lz_data_terminal,
    input  logic        lz_mfifo_full,
    input  logic        lz_compress_done,
    input  logic [31:0] lz_compressed_len,
    output logic        busy,
    output logic        job_done,
    output logic [1:0]  job_status,
    output logic [31:0] job_clen
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_LEN       = 3'd2;
    localparam logic [2:0] S_FEED      = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_REPORT    = 3'd5;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_TIMEOUT  = 2'd1;
    localparam logic [1:0] ST_TOO_LONG = 2'd2;
    localparam logic [1:0] ST_EARLY    = 2'd3;

    // Watchdog is a down-counter: loaded with TIMEOUT-1, expires when it is
    // already zero on a cycle without progress, i.e. after TIMEOUT idle cycles.
    localparam logic [19:0] WDOG_LOAD = TIMEOUT_CYCLES - 20'd1;

    logic [2:0]  state;
    logic [31:0] len_q;
    logic [30:0] words_left;
    logic [19:0] wdog;
    logic [1:0]  status_q;
    logic [31:0] clen_q;

    logic [30:0] words_init;
    logic        xfer;
    logic        last_word;
    logic        wdog_zero;
    logic        len_active;

    // Dword count = ceil(len/4); split so the +3 can never overflow 32 bits.
    always_comb begin
        words_init = {1'b0, job_len[31:2]} + {30'd0, |job_len[1:0]};
    end

    // Transfer qualification and length-hold window.
    always_comb begin
        xfer       = (state == S_FEED) && src_valid && !lz_mfifo_full
                     && (words_left != 31'd0);
        last_word  = (words_left == 31'd1);
        wdog_zero  = (wdog == 20'd0);
        len_active = (state == S_LEN) || (state == S_FEED)
                     || (state == S_WAIT_DONE) || (state == S_REPORT);
    end

    // Main sequencer: state, length, dword counter, watchdog and result capture.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= S_IDLE;
            len_q      <= 32'd0;
            words_left <= 31'd0;
            wdog       <= 20'd0;
            status_q   <= ST_OK;
            clen_q     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        words_left <= words_init;
                        if (job_len == 32'd0) begin
                            len_q    <= 32'd0;
                            status_q <= ST_OK;
                            clen_q   <= 32'd0;
                            state    <= S_REPORT;
                        end else if (job_len > MAX_LEN) begin
                            len_q    <= 32'd0;
                            status_q <= ST_TOO_LONG;
                            clen_q   <= 32'd0;
                            state    <= S_REPORT;
                        end else begin
                            len_q <= job_len;
                            state <= S_START;
                        end
                    end
                end
                S_START: begin
                    state <= S_LEN;
                end
                S_LEN: begin
                    wdog  <= WDOG_LOAD;
                    state <= S_FEED;
                end
                S_FEED: begin
                    // An early done outranks everything, including a terminal
                    // transfer happening in the same cycle.
                    if (lz_compress_done) begin
                        if (xfer) begin
                            words_left <= words_left - 31'd1;
                        end
                        status_q <= ST_EARLY;
                        clen_q   <= lz_compressed_len;
                        state    <= S_REPORT;
                    end else if (xfer) begin
                        words_left <= words_left - 31'd1;
                        wdog       <= WDOG_LOAD;
                        if (last_word) begin
                            state <= S_WAIT_DONE;
                        end
                    end else if (wdog_zero) begin
                        status_q <= ST_TIMEOUT;
                        clen_q   <= 32'd0;
                        state    <= S_REPORT;
                    end else begin
                        wdog <= wdog - 20'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (lz_compress_done) begin
                        status_q <= ST_OK;
                        clen_q   <= lz_compressed_len;
                        state    <= S_REPORT;
                    end else if (wdog_zero) begin
                        status_q <= ST_TIMEOUT;
                        clen_q   <= 32'd0;
                        state    <= S_REPORT;
                    end else begin
                        wdog <= wdog - 20'd1;
                    end
                end
                S_REPORT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from state; the data path is combinational so a dword
    // moves in the same cycle the source head is valid and the core has room.
    always_comb begin
        job_ready            = (state == S_IDLE);
        busy                 = (state != S_IDLE);
        lz_start_compress    = (state == S_START);
        lz_file_length_valid = (state == S_LEN);
        lz_file_length       = len_active ? len_q : 32'd0;
        src_rd               = xfer;
        lz_idata_req         = xfer;
        lz_idata             = xfer ? src_data : 32'd0;
        lz_data_terminal     = xfer && last_word;
        job_done             = (state == S_REPORT);
        job_status           = (state == S_REPORT) ? status_q : ST_OK;
        job_clen             = clen_q;
    end

endmodule

// File: tb/tb_lz4_job_scheduler.sv
// Directed bench for lz4_job_scheduler: a table of job descriptors with
// hand-computed cycle timings, plus a hand-written mid-job reset sequence.
// Cycle 0 of every job is the cycle job_valid is first presented.
module tb_lz4_job_scheduler;

    logic        clk;
    logic        rstN;
    logic [31:0] job_len;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_rd;
    logic        lz_start_compress;
    logic [31:0] lz_file_length;
    logic        lz_file_length_valid;
    logic [31:0] lz_idata;
    logic        lz_idata_req;
    logic        lz_data_terminal;
    logic        lz_mfifo_full;
    logic        lz_compress_done;
    logic [31:0] lz_compressed_len;
    logic        busy;
    logic        job_done;
    logic [1:0]  job_status;
    logic [31:0] job_clen;

    int checks   = 0;
    int failures = 0;

    logic [31:0] srcq[$];

    lz4_job_scheduler #(
        .TIMEOUT_CYCLES(20'd16),
        .MAX_LEN       (32'h00400000)
    ) dut (
        .clk                 (clk),
        .rstN                (rstN),
        .job_len             (job_len),
        .job_valid           (job_valid),
        .job_ready           (job_ready),
        .src_data            (src_data),
        .src_valid           (src_valid),
        .src_rd              (src_rd),
        .lz_start_compress   (lz_start_compress),
        .lz_file_length      (lz_file_length),
        .lz_file_length_valid(lz_file_length_valid),
        .lz_idata            (lz_idata),
        .lz_idata_req        (lz_idata_req),
        .lz_data_terminal    (lz_data_terminal),
        .lz_mfifo_full       (lz_mfifo_full),
        .lz_compress_done    (lz_compress_done),
        .lz_compressed_len   (lz_compressed_len),
        .busy                (busy),
        .job_done            (job_done),
        .job_status          (job_status),
        .job_clen            (job_clen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "bench time limit");
    end

    typedef struct {
        logic [31:0] len;
        int          nwords;
        int          full_mode;   // >0: full during alternate blocks of this many cycles
        int          done_at;     // absolute cycle to raise compress_done, -1 none
        int          done_delay;  // cycles after terminal to raise compress_done, -1 none
        int          stall_from;  // source forced empty in [stall_from, stall_to]
        int          stall_to;
        logic [31:0] clen_in;
        int          exp_start;
        int          exp_req;
        int          exp_term_idx;
        int          exp_done_cyc;
        logic [1:0]  exp_status;
        bit          chk_clen;
        logic [31:0] exp_clen;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v, input int vid);
        int          req_cnt, rd_cnt, start_cnt, start_cyc, lens_cyc;
        int          term_cnt, term_idx, term_cyc, done_cyc;
        int          data_err, full_err, busy_err, lenv_err;
        logic        rd_now;
        logic [1:0]  st;
        logic [31:0] cl;
        logic [31:0] expq[$];
        string       tag;
        tag = $sformatf("v%0d", vid);
        srcq.delete();
        for (int i = 0; i < v.nwords; i++) begin
            srcq.push_back(32'hC0DE_0000 + (vid << 8) + i);
        end
        expq = srcq;
        req_cnt = 0; rd_cnt = 0; start_cnt = 0; start_cyc = -1; lens_cyc = -1;
        term_cnt = 0; term_idx = 0; term_cyc = -1; done_cyc = -1;
        data_err = 0; full_err = 0; busy_err = 0; lenv_err = 0;
        st = 2'd0; cl = 32'd0;
        lz_compressed_len = v.clen_in;
        for (int c = 0; c < 200 && done_cyc < 0; c++) begin
            job_len          = v.len;
            job_valid        = 1'b1;   // held high for the whole job
            lz_compress_done = (v.done_at >= 0 && c >= v.done_at) ||
                               (v.done_delay >= 0 && term_cyc >= 0 &&
                                c >= term_cyc + v.done_delay);
            lz_mfifo_full    = (v.full_mode > 0) && (((c / v.full_mode) % 2) == 1);
            src_valid        = (srcq.size() > 0) && !(c >= v.stall_from && c <= v.stall_to);
            src_data         = src_valid ? srcq[0] : 32'h0;
            #1;
            if (c == 0) begin
                chk({tag, "_ready_idle"}, job_ready, 1);
                chk({tag, "_busy_idle"}, busy, 0);
            end else if (job_ready || !busy) begin
                busy_err++;
            end
            if (lz_start_compress) begin
                start_cnt++;
                start_cyc = c;
            end
            if (lz_file_length_valid) lens_cyc = c;
            if (lens_cyc < 0 && lz_file_length != 32'd0) lenv_err++;
            if (lens_cyc >= 0 && lz_file_length != v.len) lenv_err++;
            rd_now = src_rd;
            if (src_rd) rd_cnt++;
            if (lz_idata_req) begin
                req_cnt++;
                if (req_cnt > expq.size()) data_err++;
                else if (lz_idata !== expq[req_cnt-1]) data_err++;
                if (!src_rd) data_err++;
                if (lz_mfifo_full) full_err++;
            end else if (lz_idata != 32'd0) begin
                data_err++;
            end
            if (lz_data_terminal) begin
                term_cnt++;
                term_idx = req_cnt;
                term_cyc = c;
                if (!lz_idata_req) data_err++;
            end
            if (job_done) begin
                done_cyc = c;
                st = job_status;
                cl = job_clen;
            end
            @(posedge clk);
            if (rd_now && srcq.size() > 0) void'(srcq.pop_front());
            #1;
        end
        job_valid        = 1'b0;
        lz_compress_done = 1'b0;
        src_valid        = 1'b0;
        src_data         = 32'h0;
        lz_mfifo_full    = 1'b0;
        #1;
        chk({tag, "_start_cnt"}, start_cnt, v.exp_start);
        if (v.exp_start > 0) begin
            chk({tag, "_start_cyc"}, start_cyc, 1);
            chk({tag, "_lenstrobe_cyc"}, lens_cyc, 2);
        end else begin
            chk({tag, "_no_lenstrobe"}, lens_cyc, -1);
        end
        chk({tag, "_req_cnt"}, req_cnt, v.exp_req);
        chk({tag, "_rd_cnt"}, rd_cnt, v.exp_req);
        chk({tag, "_term_cnt"}, term_cnt, (v.exp_term_idx > 0) ? 1 : 0);
        chk({tag, "_term_idx"}, term_idx, v.exp_term_idx);
        chk({tag, "_data_err"}, data_err, 0);
        chk({tag, "_req_while_full"}, full_err, 0);
        chk({tag, "_busy_err"}, busy_err, 0);
        chk({tag, "_file_length_err"}, lenv_err, 0);
        chk({tag, "_done_cyc"}, done_cyc, v.exp_done_cyc);
        chk({tag, "_status"}, st, v.exp_status);
        if (v.chk_clen) chk({tag, "_clen"}, cl, v.exp_clen);
        chk({tag, "_ready_after"}, job_ready, 1);
        chk({tag, "_done_pulse_1cyc"}, job_done, 0);
        chk({tag, "_clen_held"}, job_clen, cl);
    endtask

    initial begin
        //                len            nw full at  dly sfrom stot clen_in st req ti dcyc sts chk exp_clen
        vecs[0]  = '{32'd16,          4, 0, -1,  2, 1000, 0, 32'd9,  1, 4,  4,  9, 2'd0, 1'b1, 32'd9};
        vecs[1]  = '{32'd5,           2, 0, -1,  1, 1000, 0, 32'd3,  1, 2,  2,  6, 2'd0, 1'b1, 32'd3};
        vecs[2]  = '{32'd0,           0, 0, -1,  1, 1000, 0, 32'd77, 0, 0,  0,  1, 2'd0, 1'b1, 32'd0};
        vecs[3]  = '{32'd40,         10, 3, -1,  1, 1000, 0, 32'd21, 1, 10, 10, 26, 2'd0, 1'b1, 32'd21};
        vecs[4]  = '{32'd32,          2, 0, -1, -1, 1000, 0, 32'd0,  1, 2,  0, 21, 2'd1, 1'b0, 32'd0};
        vecs[5]  = '{32'd4,           1, 0, -1, -1, 1000, 0, 32'd0,  1, 1,  1, 20, 2'd1, 1'b0, 32'd0};
        vecs[6]  = '{32'h00400001,    0, 0, -1, -1, 1000, 0, 32'd0,  0, 0,  0,  1, 2'd2, 1'b0, 32'd0};
        vecs[7]  = '{32'd32,          8, 0,  5, -1, 1000, 0, 32'd0,  1, 3,  0,  6, 2'd3, 1'b0, 32'd0};
        vecs[8]  = '{32'd8,           2, 0,  4, -1, 1000, 0, 32'd0,  1, 2,  2,  5, 2'd3, 1'b0, 32'd0};
        vecs[9]  = '{32'd8,           2, 0, -1,  1,    4, 18, 32'd5, 1, 2,  2, 21, 2'd0, 1'b1, 32'd5};
        vecs[10] = '{32'd8,           2, 0, -1, -1,    4, 19, 32'd0, 1, 1,  0, 20, 2'd1, 1'b0, 32'd0};
        vecs[11] = '{32'd1,           1, 0, -1,  3, 1000, 0, 32'd1,  1, 1,  1,  7, 2'd0, 1'b1, 32'd1};

        rstN = 1'b0; job_len = 32'd0; job_valid = 1'b0; src_data = 32'd0; src_valid = 1'b0;
        lz_mfifo_full = 1'b0; lz_compress_done = 1'b0; lz_compressed_len = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_job_ready", job_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_outputs_or", {src_rd, lz_start_compress, lz_file_length_valid, lz_idata_req,
                                 lz_data_terminal, job_done, job_status} , 0);
        chk("reset_clen", job_clen, 0);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_job(vecs[i], i);
        end

        // Reset asserted mid-FEED: everything drops at once, no report.
        job_len = 32'd32; job_valid = 1'b1; src_valid = 1'b1; src_data = 32'hDEAD_0001;
        lz_mfifo_full = 1'b0; lz_compress_done = 1'b0;
        @(posedge clk); #1; job_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst_pre_req", lz_idata_req, 1);
        chk("midrst_pre_busy", busy, 1);
        #2;
        rstN = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", job_ready, 1);
        chk("midrst_req", {lz_idata_req, src_rd, lz_data_terminal}, 0);
        chk("midrst_idata", lz_idata, 0);
        chk("midrst_file_length", lz_file_length, 0);
        chk("midrst_clen", job_clen, 0);
        @(posedge clk); #1;
        chk("midrst_no_done", job_done, 0);
        src_valid = 1'b0;
        rstN = 1'b1;
        @(posedge clk); #1;
        chk("midrst_idle_after", job_ready, 1);
        run_job(vecs[0], 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
